// File: rtl/rs_encoder.sv
// Systematic RS(15,11) encoder over GF(16), g(x) roots alpha^1..alpha^4, valid/ready streaming.
// Optional error injection on the output path is enabled by defining RS_ENC_ERR_INJECT_EN.
module rs_encoder (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [3:0] OUT_DATA,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       OUT_FIRST,
    output logic       OUT_LAST
`ifdef RS_ENC_ERR_INJECT_EN
    ,
    input  logic [3:0] ERR_POS,
    input  logic [3:0] ERR_VAL
`endif
);

    typedef enum logic {ST_MSG = 1'b0, ST_PARITY = 1'b1} state_e;

    // GF(16) multiply, field polynomial x^4+x+1 (x^4 reduces to 4'h3).
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[2:0], 1'b0} ^ {2'b00, aa[3], aa[3]};
        end
        return p;
    endfunction

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [3:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_first_q, out_first_d;
    logic       out_last_q, out_last_d;
    logic       slot_free_s, in_beat_s, load_s;
    logic [3:0] fb_s, sym_s, inj_s;

    assign slot_free_s = ~out_valid_q | OUT_READY;
    assign IN_READY    = (state_q == ST_MSG) & slot_free_s;
    assign in_beat_s   = IN_VALID & IN_READY;
    assign fb_s        = IN_DATA ^ r3_q;

`ifdef RS_ENC_ERR_INJECT_EN
    logic [3:0] err_pos_q, err_pos_d, err_val_q, err_val_d;
    logic [3:0] pos_s, val_s, idx_s;
    logic       cw_start_s;

    // Injection control: first message beat latches position/value for the whole codeword.
    always_comb begin
        cw_start_s = (state_q == ST_MSG) && (cnt_q == 4'd0);
        pos_s      = cw_start_s ? ERR_POS : err_pos_q;
        val_s      = cw_start_s ? ERR_VAL : err_val_q;
        idx_s      = (state_q == ST_MSG) ? cnt_q : (cnt_q + 4'd11);
        inj_s      = (idx_s == pos_s) ? val_s : 4'h0;
        err_pos_d  = (cw_start_s && in_beat_s) ? ERR_POS : err_pos_q;
        err_val_d  = (cw_start_s && in_beat_s) ? ERR_VAL : err_val_q;
    end

    // Injection registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            err_pos_q <= 4'hF;
            err_val_q <= 4'h0;
        end else begin
            err_pos_q <= err_pos_d;
            err_val_q <= err_val_d;
        end
    end
`else
    assign inj_s = 4'h0;
`endif

    // Next-state: LFSR division during MSG, parity shift-out during PARITY, hold while stalled.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r0_d        = r0_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        sym_s       = 4'h0;
        load_s      = 1'b0;
        if (!slot_free_s) begin
            load_s = 1'b0;
        end else begin
            case (state_q)
                ST_MSG: begin
                    if (in_beat_s) begin
                        sym_s       = IN_DATA;
                        load_s      = 1'b1;
                        out_valid_d = 1'b1;
                        out_first_d = (cnt_q == 4'd0);
                        out_last_d  = 1'b0;
                        r3_d        = r2_q ^ gf_mul(fb_s, 4'hD);
                        r2_d        = r1_q ^ gf_mul(fb_s, 4'hC);
                        r1_d        = r0_q ^ gf_mul(fb_s, 4'h8);
                        r0_d        = gf_mul(fb_s, 4'h7);
                        if (cnt_q == 4'd10) begin
                            cnt_d   = 4'd0;
                            state_d = ST_PARITY;
                        end else begin
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end else begin
                        out_valid_d = 1'b0;
                        out_first_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
                ST_PARITY: begin
                    sym_s       = r3_q;
                    load_s      = 1'b1;
                    out_valid_d = 1'b1;
                    out_first_d = 1'b0;
                    out_last_d  = (cnt_q == 4'd3);
                    r3_d        = r2_q;
                    r2_d        = r1_q;
                    r1_d        = r0_q;
                    r0_d        = 4'h0;
                    if (cnt_q == 4'd3) begin
                        cnt_d   = 4'd0;
                        state_d = ST_MSG;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d     = ST_MSG;
                    cnt_d       = 4'd0;
                    out_valid_d = 1'b0;
                    out_first_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            endcase
        end
        if (load_s) begin
            out_data_d = sym_s ^ inj_s;
        end else begin
            out_data_d = out_data_q;
        end
    end

    // State, LFSR and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_MSG;
            cnt_q       <= 4'd0;
            r0_q        <= 4'h0;
            r1_q        <= 4'h0;
            r2_q        <= 4'h0;
            r3_q        <= 4'h0;
            out_data_q  <= 4'h0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_FIRST = out_first_q;
    assign OUT_LAST  = out_last_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Scoreboard bench for rs_encoder: reference parity by polynomial long division.
module tb_rs_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] err_pos = 4'hF;
    logic [3:0] err_val = 4'h0;
    wire        in_ready;
    wire  [3:0] out_data;
    wire        out_valid, out_first, out_last;

    typedef struct packed {
        logic [3:0] data;
        logic       first;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  msgs[0:3][0:10];
    logic [15:0] par_tab[0:3];
    logic [3:0]  errp[0:3];
    logic [3:0]  errv[0:3];
    int          tests_run = 0;
    int          tests_failed = 0;

    rs_encoder dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_FIRST (out_first),
        .OUT_LAST  (out_last)
`ifdef RS_ENC_ERR_INJECT_EN
        ,
        .ERR_POS   (err_pos),
        .ERR_VAL   (err_val)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        logic       c;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            c = x[3];
            x = {x[2:0], 1'b0};
            if (c) x = x ^ 4'h3;
        end
        return p;
    endfunction

    // Remainder of m(x)*x^4 divided by g(x); returned highest degree first.
    function automatic logic [15:0] model_parity(input int cw);
        logic [3:0] c[0:14];
        logic [3:0] g[0:4];
        logic [3:0] q;
        g = '{4'h7, 4'h8, 4'hC, 4'hD, 4'h1};
        for (int i = 0; i < 15; i++) c[i] = 4'h0;
        for (int i = 0; i < 11; i++) c[14-i] = msgs[cw][i];
        for (int d = 14; d >= 4; d--) begin
            q = c[d];
            for (int j = 0; j <= 4; j++) c[d-4+j] = c[d-4+j] ^ gmul(q, g[j]);
        end
        return {c[3], c[2], c[1], c[0]};
    endfunction

    task automatic push_codeword(input int cw);
        exp_t e;
        for (int i = 0; i < 15; i++) begin
            e.data  = (i < 11) ? msgs[cw][i] : par_tab[cw][(14-i)*4 +: 4];
            if (i == int'(errp[cw])) e.data = e.data ^ errv[cw];
            e.first = (i == 0);
            e.last  = (i == 14);
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_err();
        for (int i = 0; i < 4; i++) begin
            errp[i] = 4'hF;
            errv[i] = 4'h0;
        end
    endtask

    task automatic random_msgs(input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 11; i++) msgs[c][i] = 4'($urandom_range(15));
            par_tab[c] = model_parity(c);
        end
    endtask

    // Streams n_cw codewords from msgs[], checking every output beat against the scoreboard.
    task automatic run_stream(input int n_cw, input int stall_pct, input int gap_pct,
                              output int ready_low, output int cycles);
        int   cw;
        int   idx;
        bit   hold;
        logic [6:0] held;
        exp_t e;
        cw = 0; idx = 0; hold = 1'b0; held = 7'h0;
        ready_low = 0; cycles = 0;
        while (cw < n_cw || exp_q.size() != 0) begin
            @(negedge clk);
            cycles++;
            if (cycles > 3000) begin
                tests_run++; tests_failed++;
                $display("FAIL stream_timeout: %0d symbols still expected after %0d cycles", exp_q.size(), cycles);
                break;
            end
            in_valid  = (cw < n_cw) && ($urandom_range(99) >= gap_pct);
            in_data   = in_valid ? msgs[cw][idx] : 4'($urandom_range(15));
            out_ready = ($urandom_range(99) >= stall_pct);
            err_pos   = (cw < n_cw) ? errp[cw] : 4'hF;
            err_val   = (cw < n_cw) ? errv[cw] : 4'h0;
            #1;
            if (hold) begin
                tests_run++;
                if ({out_valid, out_data, out_first, out_last} !== held) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got %h required %h", {out_valid, out_data, out_first, out_last}, held);
                end
            end
            hold = out_valid && !out_ready;
            held = {out_valid, out_data, out_first, out_last};
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL extra_beat: got data %h with nothing expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_first, out_last} !== e) begin
                        tests_failed++;
                        $display("FAIL beat: got data=%h first=%b last=%b required data=%h first=%b last=%b",
                                 out_data, out_first, out_last, e.data, e.first, e.last);
                    end
                end
            end
            if (cw >= 1 && cw < n_cw && !in_ready) ready_low++;
            if (in_valid && in_ready) begin
                if (idx == 0) push_codeword(cw);
                idx++;
                if (idx == 11) begin
                    idx = 0;
                    cw++;
                end
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 4'hA;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_data, out_first, out_last} !== 7'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 00", {out_valid, out_data, out_first, out_last});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero_codeword();
        int rl, cyc;
        clear_err();
        for (int i = 0; i < 11; i++) msgs[0][i] = 4'h0;
        par_tab[0] = 16'h0000;
        run_stream(1, 0, 0, rl, cyc);
        tests_run++;
        if (cyc !== 16) begin
            tests_failed++;
            $display("FAIL zero_latency: got %0d cycles required 16", cyc);
        end
    endtask

    task automatic test_known_parity();
        int rl, cyc;
        clear_err();
        for (int i = 0; i < 11; i++) begin
            msgs[0][i] = 4'h0;
            msgs[1][i] = 4'h0;
        end
        msgs[0][10] = 4'h1;
        msgs[1][10] = 4'h2;
        par_tab[0] = 16'hDC87;
        par_tab[1] = 16'h9B3E;
        run_stream(2, 0, 0, rl, cyc);
    endtask

    task automatic test_back_to_back();
        int rl, cyc;
        clear_err();
        random_msgs(2);
        run_stream(2, 0, 0, rl, cyc);
        tests_run++;
        if (rl !== 4) begin
            tests_failed++;
            $display("FAIL b2b_ready_gap: got %0d low cycles required 4", rl);
        end
        tests_run++;
        if (cyc !== 31) begin
            tests_failed++;
            $display("FAIL b2b_throughput: got %0d cycles required 31", cyc);
        end
    endtask

    task automatic test_stalls();
        int rl, cyc;
        clear_err();
        for (int r = 0; r < 3; r++) begin
            random_msgs(3);
            run_stream(3, 40, 30, rl, cyc);
        end
    endtask

    task automatic test_reset_mid();
        int rl, cyc;
        clear_err();
        random_msgs(1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = msgs[0][i];
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_data, out_first, out_last} !== 7'h00) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %h required 00", {out_valid, out_data, out_first, out_last});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_ready: got %b required 1", in_ready);
        end
        random_msgs(1);
        run_stream(1, 0, 0, rl, cyc);
    endtask

`ifdef RS_ENC_ERR_INJECT_EN
    task automatic test_err_inject();
        int rl, cyc;
        clear_err();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 11; i++) msgs[c][i] = 4'h0;
            msgs[c][10] = 4'h1;
            par_tab[c] = 16'hDC87;
        end
        errp[0] = 4'd12; errv[0] = 4'h5;
        errp[1] = 4'd3;  errv[1] = 4'h0;
        errp[2] = 4'd0;  errv[2] = 4'hF;
        run_stream(3, 20, 10, rl, cyc);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_codeword();
        test_known_parity();
        test_back_to_back();
        test_stalls();
        test_reset_mid();
`ifdef RS_ENC_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
